// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Purpose  : Shares the single byte-wide RAM port between instruction fetch
//            (IF) and the load/store stage (MEM). Multi-byte accesses are
//            built from single-byte RAM cycles, little-endian. MEM has strict
//            priority. Per-stage stall requests are combinational.
// Ports    : clk, rst (async active-low), rdy (1 = run, 0 = freeze)
//            if_req/if_addr/if_data/if_done        - fetch side
//            mem_req/mem_we/mem_width/mem_addr/
//            mem_wdata/mem_rdata/mem_done          - load/store side
//            ram_din/ram_dout/ram_addr/ram_wr      - byte RAM port
//            stall_req_if/stall_req_mem            - to pipeline controller
// Options  : IF_LAST_HIT_EN - one-entry buffer of the last fetched word;
//            a repeat fetch of the same address completes without RAM cycles.
// Notes    : ADDR_W must be below 32.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int   ADDR_W    = 17,
  parameter logic BUSY_ZERO = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_data,
  output logic              if_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [1:0]        mem_width,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_done,
  input  logic [7:0]        ram_din,
  output logic [7:0]        ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wr,
  output logic              stall_req_if,
  output logic              stall_req_mem
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ADDR_W-1:0]  base;
  logic [2:0]         len;        // bytes in the access: 1, 2 or 4
  logic [2:0]         cnt;        // cycle index inside RD / WR
  logic               owner_mem;  // 1 = current access belongs to MEM
  logic [23:0]        wdata_hi;   // store bytes 1..3; byte 0 goes out at accept
  logic               wr_q;

  logic               accept_mem;
  logic               accept_if;
  logic               take_hit;
  logic               lb_hit;
  logic [2:0]         width_len;
  logic [1:0]         cap_idx;

  // Upper address bits are outside the RAM and deliberately ignored.
  logic               unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[31:ADDR_W], mem_addr[31:ADDR_W]};

  always_comb begin
    case (mem_width)
      2'd0:    width_len = 3'd1;
      2'd1:    width_len = 3'd2;
      default: width_len = 3'd4;
    endcase
  end

  // Read data for RAM address issued in RD cycle k arrives in cycle k+1,
  // so the byte captured in cycle cnt is byte cnt-1.
  assign cap_idx = cnt[1:0] - 2'd1;

  // --------------------------------------------------------------------------
  // Optional last-fetch buffer. if_data is only ever written by IF reads, so
  // it doubles as the buffered word.
  // --------------------------------------------------------------------------
`ifdef IF_LAST_HIT_EN
  logic        lb_valid;
  logic [31:0] lb_addr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lb_valid <= 1'b0;
      lb_addr  <= '0;
    end else if (rdy) begin
      if (accept_mem && mem_we) begin
        lb_valid <= 1'b0;
      end else if (accept_if) begin
        lb_valid <= 1'b0;
        lb_addr  <= if_addr;
      end else if (state == RD && !owner_mem && cnt == len) begin
        lb_valid <= 1'b1;
      end
    end
  end

  assign lb_hit = lb_valid && (if_addr == lb_addr);
`else
  assign lb_hit = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    take_hit   = 1'b0;
    case (state)
      IDLE: begin
        if (mem_req) begin
          accept_mem = 1'b1;
          state_nxt  = mem_we ? WR : RD;
        end else if (if_req) begin
          if (lb_hit) begin
            take_hit  = 1'b1;
            state_nxt = DONE;
          end else begin
            accept_if = 1'b1;
            state_nxt = RD;
          end
        end
      end
      RD:      if (cnt == len) state_nxt = DONE;
      WR:      if (cnt + 3'd1 == len) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base      <= '0;
      len       <= 3'd0;
      cnt       <= 3'd0;
      owner_mem <= 1'b0;
      wdata_hi  <= '0;
      wr_q      <= 1'b0;
      ram_addr  <= '0;
      ram_dout  <= 8'd0;
      if_data   <= 32'd0;
      mem_rdata <= 32'd0;
      if_done   <= 1'b0;
      mem_done  <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          if (accept_mem) begin
            owner_mem <= 1'b1;
            base      <= mem_addr[ADDR_W-1:0];
            len       <= width_len;
            cnt       <= 3'd0;
            ram_addr  <= mem_addr[ADDR_W-1:0];
            wdata_hi  <= mem_wdata[31:8];
            if (mem_we) begin
              ram_dout <= mem_wdata[7:0];
              wr_q     <= 1'b1;
            end else begin
              mem_rdata <= 32'd0;  // zero-extension for byte/half loads
            end
          end else if (accept_if) begin
            owner_mem <= 1'b0;
            base      <= if_addr[ADDR_W-1:0];
            len       <= 3'd4;
            cnt       <= 3'd0;
            ram_addr  <= if_addr[ADDR_W-1:0];
          end else if (take_hit) begin
            owner_mem <= 1'b0;
            if_done   <= 1'b1;
          end
        end
        RD: begin
          if (cnt + 3'd1 < len) begin
            ram_addr <= base + ADDR_W'(cnt + 3'd1);
          end
          if (cnt != 3'd0) begin
            if (owner_mem) mem_rdata[8*cap_idx +: 8] <= ram_din;
            else           if_data[8*cap_idx +: 8]   <= ram_din;
          end
          if (cnt == len) begin
            if (owner_mem) mem_done <= 1'b1;
            else           if_done  <= 1'b1;
          end
          cnt <= cnt + 3'd1;
        end
        WR: begin
          if (cnt + 3'd1 < len) begin
            ram_addr <= base + ADDR_W'(cnt + 3'd1);
            ram_dout <= wdata_hi[8*cnt[1:0] +: 8];
          end else begin
            wr_q     <= 1'b0;
            mem_done <= 1'b1;
          end
          cnt <= cnt + 3'd1;
        end
        default: begin
          if_done  <= 1'b0;
          mem_done <= 1'b0;
        end
      endcase
    end
  end

  // A frozen cycle must never commit a RAM write.
  assign ram_wr = wr_q & rdy;

  assign stall_req_if  = BUSY_ZERO ^ (if_req & ~if_done);
  assign stall_req_mem = BUSY_ZERO ^ (mem_req & ~mem_done);

endmodule
`default_nettype wire
